// File: rtl/tqvp_gera_gray_engine.sv
// Gray-code engine peripheral.
// - Binary-to-Gray conversion in a single cycle.
// - Gray-to-binary conversion, one bit per cycle, MSB first.
// - Free-running or externally stepped binary counter, exposed as a Gray count.
// Register handshake: a write is a single-cycle data_write pulse with address and
// data_in valid in that same cycle; reads are combinational on address (no ready).
module tqvp_gera_gray_engine #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       fsm_state
);

  localparam int HW = WIDTH - 8;
  localparam int IW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  state_e           state;
  logic [3:0]       ctrl;      // {ext_step, out_sel, dir, cnt_en}
  logic             done;
  logic             wrap;
  logic [WIDTH-1:0] op;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] cnt_next;
  logic [IW-1:0]    bit_idx;
  logic             carry;     // most recently produced result bit
  logic             ui_q;
  logic             step;
  logic             wrap_set;
  logic             busy;

  logic wr_ctrl, wr_status, wr_op_lo, wr_op_hi, wr_cmd, wr_cnt_lo, wr_cnt_hi, clr;

  logic [15:0] op_x, res_x, gray_x;
  logic        unused_ui;

  assign wr_ctrl   = data_write && (address == 4'h0);
  assign wr_status = data_write && (address == 4'h1);
  assign wr_op_lo  = data_write && (address == 4'h2);
  assign wr_op_hi  = data_write && (address == 4'h3);
  assign wr_cmd    = data_write && (address == 4'h4);
  assign wr_cnt_lo = data_write && (address == 4'h8);
  assign wr_cnt_hi = data_write && (address == 4'h9);
  assign clr       = wr_ctrl && data_in[7];

  assign busy      = (state == CONV);
  assign fsm_state = state;
  assign unused_ui = ^ui_in[7:1];

  // Registered copy of the external step input for rising-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) ui_q <= 1'b0;
    else        ui_q <= ui_in[0];
  end

  // Step qualification and next binary count; a byte load beats a step
  always_comb begin
    step     = 1'b0;
    wrap_set = 1'b0;
    cnt_next = cnt;
    if (ctrl[0]) step = ctrl[3] ? (ui_in[0] && !ui_q) : 1'b1;
    if (wr_cnt_lo) begin
      cnt_next[7:0] = data_in;
    end else if (wr_cnt_hi) begin
      cnt_next[WIDTH-1:8] = data_in[HW-1:0];
    end else if (step) begin
      if (ctrl[1]) begin
        wrap_set = (cnt == '0);
        cnt_next = cnt - WIDTH'(1);
      end else begin
        wrap_set = (cnt == '1);
        cnt_next = cnt + WIDTH'(1);
      end
    end
  end

  // Control register, counter, registered Gray count and sticky WRAP flag
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      ctrl <= '0;
      cnt  <= '0;
      gray <= '0;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      gray <= cnt_next ^ (cnt_next >> 1);
      if (wr_ctrl) ctrl <= data_in[3:0];
      if (wrap_set)                     wrap <= 1'b1;
      else if (wr_status && data_in[2]) wrap <= 1'b0;
    end
  end

  // Conversion FSM: operand register, result, DONE flag
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state   <= IDLE;
      op      <= '0;
      res     <= '0;
      done    <= 1'b0;
      bit_idx <= '0;
      carry   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_op_lo) op[7:0]       <= data_in;
          if (wr_op_hi) op[WIDTH-1:8] <= data_in[HW-1:0];
          if (wr_cmd && (data_in == 8'h01)) begin
            res  <= op ^ (op >> 1);
            done <= 1'b1;
          end else if (wr_cmd && (data_in == 8'h02)) begin
            state   <= CONV;
            res     <= '0;
            done    <= 1'b0;
            bit_idx <= IW'(WIDTH - 1);
            carry   <= 1'b0;
          end else if (wr_status && data_in[1]) begin
            done <= 1'b0;
          end
        end
        CONV: begin
          res[bit_idx] <= op[bit_idx] ^ carry;
          carry        <= op[bit_idx] ^ carry;
          bit_idx      <= bit_idx - 1'b1;
          if (bit_idx == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign op_x   = 16'(op);
  assign res_x  = 16'(res);
  assign gray_x = 16'(gray);

  // Combinational register read mux
  always_comb begin
    data_out = 8'h00;
    case (address)
      4'h0:    data_out = {4'h0, ctrl};
      4'h1:    data_out = {5'h00, wrap, done, busy};
      4'h2:    data_out = op_x[7:0];
      4'h3:    data_out = op_x[15:8];
      4'h5:    data_out = res_x[7:0];
      4'h6:    data_out = res_x[15:8];
      4'h8:    data_out = gray_x[7:0];
      4'h9:    data_out = gray_x[15:8];
      default: data_out = 8'h00;
    endcase
  end

  assign uo_out = ctrl[2] ? res[7:0] : gray[7:0];

endmodule
